// File: rtl/tff_toggle_scheduler.sv
// Round-robin scheduler that owns a bank of T flip-flops and applies one
// granted requester's toggle burst at a time, one toggle per RUN step.

// Single T flip-flop of the bank; the scheduler supplies a gated toggle strobe.
module tff_toggle_cell (
    input  logic clk,
    input  logic rst,
    input  logic t,
    output logic q
);
    // Flip on strobe, clear on reset.
    always_ff @(posedge clk) begin
        if (rst)    q <= 1'b0;
        else if (t) q <= ~q;
    end
endmodule

module tff_toggle_scheduler #(
    parameter int NREQ  = 4,
    parameter int NBITS = 8,
    parameter int GAP   = 0
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        ena,
    input  logic [NREQ-1:0]             req,
    input  logic [NREQ*$clog2(NBITS)-1:0] tgt,
    input  logic [NREQ*4-1:0]           cnt,
    output logic [NREQ-1:0]             gnt,
    output logic [NREQ-1:0]             done,
    output logic                        busy,
    output logic [NBITS-1:0]            q,
    output logic [NBITS-1:0]            tog
);
    localparam int IW = $clog2(NBITS);
    localparam int CW = 4;
    localparam int PW = $clog2(NREQ);

    typedef enum logic [1:0] {IDLE, RUN, WAIT, DONE} state_t;

    state_t          state;
    logic [PW-1:0]   ptr;
    logic [PW-1:0]   idx;
    logic [IW-1:0]   tgt_l;
    logic [CW-1:0]   rem;
    logic [2:0]      gap;

    logic            hit;
    logic [PW-1:0]   sel;
    logic [IW-1:0]   sel_tgt;
    logic [CW-1:0]   sel_cnt;
    logic [NBITS-1:0] bit_mask;
    logic [NBITS-1:0] flip;

    // Round-robin pick: first set req scanning upward from ptr, wrapping.
    always_comb begin
        hit = 1'b0;
        sel = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (!hit && req[(int'(ptr) + k) % NREQ]) begin
                hit = 1'b1;
                sel = PW'((int'(ptr) + k) % NREQ);
            end
        end
    end

    assign sel_tgt  = tgt[IW*sel +: IW];
    assign sel_cnt  = cnt[CW*sel +: CW];
    assign bit_mask = {{(NBITS-1){1'b0}}, 1'b1} << tgt_l;
    // Only the latched target flips, and only on an enabled RUN edge.
    assign flip     = (ena && state == RUN) ? bit_mask : '0;
    assign busy     = (state != IDLE);

    generate
        for (genvar i = 0; i < NBITS; i++) begin : g_bit
            tff_toggle_cell u_cell (
                .clk (clk),
                .rst (rst),
                .t   (flip[i]),
                .q   (q[i])
            );
        end
    endgenerate

    // Scheduler FSM with registered grant, done and toggle strobe.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            gnt   <= '0;
            done  <= '0;
            tog   <= '0;
            ptr   <= '0;
            idx   <= '0;
            tgt_l <= '0;
            rem   <= '0;
            gap   <= '0;
        end else if (ena) begin
            case (state)
                IDLE: begin
                    tog  <= '0;
                    done <= '0;
                    if (hit) begin
                        gnt   <= {{(NREQ-1){1'b0}}, 1'b1} << sel;
                        idx   <= sel;
                        tgt_l <= sel_tgt;
                        rem   <= sel_cnt;
                        state <= (sel_cnt != '0) ? RUN : DONE;
                    end
                end
                RUN: begin
                    tog <= bit_mask;
                    rem <= rem - 1'b1;
                    if (rem == CW'(1)) begin
                        state <= DONE;
                    end else if (GAP > 0) begin
                        gap   <= 3'(GAP);
                        state <= WAIT;
                    end
                end
                WAIT: begin
                    tog <= '0;
                    gap <= gap - 1'b1;
                    if (gap == 3'd1) state <= RUN;
                end
                DONE: begin
                    tog <= '0;
                    // First DONE edge emits the pulse; the second returns to IDLE.
                    if (done == '0) begin
                        done <= gnt;
                        gnt  <= '0;
                        ptr  <= (idx == PW'(NREQ-1)) ? '0 : idx + PW'(1);
                    end else begin
                        done  <= '0;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_tff_toggle_scheduler.sv
// Directed bench: one scheduler with GAP=0 and one with GAP=2 on a shared clock.
module tb_tff_toggle_scheduler;
    logic        clk = 1'b0;
    logic        rst, ena;
    logic [3:0]  req,  gnt,  done;
    logic [11:0] tgt;
    logic [15:0] cnt;
    logic        busy;
    logic [7:0]  q, tog;
    logic [3:0]  req2, gnt2, done2;
    logic [11:0] tgt2;
    logic [15:0] cnt2;
    logic        busy2;
    logic [7:0]  q2, tog2;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    tff_toggle_scheduler #(.NREQ(4), .NBITS(8), .GAP(0)) u0 (
        .clk(clk), .rst(rst), .ena(ena), .req(req), .tgt(tgt), .cnt(cnt),
        .gnt(gnt), .done(done), .busy(busy), .q(q), .tog(tog));

    tff_toggle_scheduler #(.NREQ(4), .NBITS(8), .GAP(2)) u2 (
        .clk(clk), .rst(rst), .ena(ena), .req(req2), .tgt(tgt2), .cnt(cnt2),
        .gnt(gnt2), .done(done2), .busy(busy2), .q(q2), .tog(tog2));

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int n, ntog;
        logic [3:0] exp_g;
        // reset with random requests
        rst = 1'b1; ena = 1'b1;
        req = 4'($urandom); tgt = 12'($urandom); cnt = 16'($urandom);
        req2 = '0; tgt2 = '0; cnt2 = '0;
        step(); step();
        chk("rst_q", q, 0); chk("rst_gnt", gnt, 0); chk("rst_done", done, 0);
        chk("rst_tog", tog, 0); chk("rst_busy", busy, 0);
        rst = 1'b0; req = '0;
        for (int i = 0; i < 4; i++) begin tgt[3*i +: 3] = 3'(i); cnt[4*i +: 4] = 4'd1; end

        // round robin with all requests held: 0,1,2,3,0 (also proves ptr reset to 0)
        req = 4'b1111;
        for (int g = 0; g < 5; g++) begin
            n = 0; while (gnt != 0 && n < 12) begin step(); n++; end
            n = 0; while (gnt == 0 && n < 12) begin step(); n++; end
            exp_g = 4'b0001 << (g % 4);
            chk($sformatf("rr_grant%0d", g), gnt, exp_g);
        end
        n = 0; while (done == 0 && n < 12) begin step(); n++; end
        chk("rr_last_done", done, 4'b0001);
        req = '0;
        step();
        chk("rr_idle", busy, 0);
        chk("rr_q", q, 8'h0E);
        rst = 1'b1; step(); rst = 1'b0;

        // single burst: requester 2, tgt 5, cnt 3
        tgt[8:6] = 3'd5; cnt[11:8] = 4'd3; req = 4'b0100;
        step(); chk("sb_gnt", gnt, 4'b0100); chk("sb_tog0", tog, 0); chk("sb_busy", busy, 1);
        step(); chk("sb_tog1", tog, 8'h20); chk("sb_q1", q, 8'h20);
        step(); chk("sb_tog2", tog, 8'h20); chk("sb_q2", q, 8'h00);
        step(); chk("sb_tog3", tog, 8'h20); chk("sb_q3", q, 8'h20);
        step(); chk("sb_done", done, 4'b0100); chk("sb_gnt_off", gnt, 0); chk("sb_tog4", tog, 0);
        req = '0;
        step(); chk("sb_done_off", done, 0); chk("sb_idle", busy, 0);

        // ena hold mid-burst and during done: requester 1, tgt 2, cnt 5
        tgt[5:3] = 3'd2; cnt[7:4] = 4'd5; req = 4'b0010;
        step(); chk("en_gnt", gnt, 4'b0010);
        step(); chk("en_tog1", tog, 8'h04); chk("en_q1", q, 8'h24);
        ena = 1'b0;
        repeat (3) step();
        chk("en_hold_q", q, 8'h24); chk("en_hold_tog", tog, 8'h04);
        chk("en_hold_gnt", gnt, 4'b0010); chk("en_hold_busy", busy, 1);
        ena = 1'b1; ntog = 1;
        n = 0; while (done == 0 && n < 30) begin step(); n++; if (tog != 0) ntog++; end
        chk("en_ntog", ntog, 5); chk("en_q_final", q, 8'h24); chk("en_done", done, 4'b0010);
        req = '0; ena = 1'b0;
        repeat (3) step();
        chk("en_done_hold", done, 4'b0010);
        ena = 1'b1;
        step(); chk("en_done_off", done, 0); chk("en_idle", busy, 0);

        // reset mid-burst; held req re-granted scanning from requester 0
        for (int i = 0; i < 4; i++) begin tgt[3*i +: 3] = 3'd1; cnt[4*i +: 4] = 4'd10; end
        req = 4'b1010;
        step(); chk("mr_gnt", gnt, 4'b1000);
        step(); step(); step(); chk("mr_q3", q, 8'h26);
        step(); chk("mr_q4", q, 8'h24); chk("mr_tog4", tog, 8'h02);
        rst = 1'b1; step(); rst = 1'b0;
        chk("mr_q", q, 0); chk("mr_busy", busy, 0); chk("mr_gnt0", gnt, 0);
        chk("mr_done", done, 0); chk("mr_tog", tog, 0);
        step(); chk("mr_regrant", gnt, 4'b0010);
        req = '0; rst = 1'b1; step(); rst = 1'b0;

        // GAP=2, cnt=2: toggles at E1 and E4
        tgt2[2:0] = 3'd3; cnt2[3:0] = 4'd2; req2 = 4'b0001;
        step(); chk("g2_gnt", gnt2, 4'b0001);
        step(); chk("g2_tog1", tog2, 8'h08); chk("g2_q1", q2, 8'h08);
        step(); chk("g2_gap1", tog2, 0);
        step(); chk("g2_gap2", tog2, 0); chk("g2_busy", busy2, 1);
        step(); chk("g2_tog4", tog2, 8'h08); chk("g2_q4", q2, 8'h00);
        step(); chk("g2_done", done2, 4'b0001);
        req2 = '0; step(); chk("g2_idle", busy2, 0);

        // GAP=2, cnt=15 on requester 1 bit 6
        tgt2[5:3] = 3'd6; cnt2[7:4] = 4'd15; req2 = 4'b0010; ntog = 0;
        n = 0; while (done2 == 0 && n < 100) begin step(); n++; if (tog2 != 0) ntog++; end
        chk("g15_ntog", ntog, 15); chk("g15_q", q2, 8'h40); chk("g15_done", done2, 4'b0010);
        chk("g15_edges", n, 45);
        req2 = '0; step();

        // GAP=2, cnt=0 on requester 2: done after E1, no toggle
        tgt2[8:6] = 3'd0; cnt2[11:8] = 4'd0; req2 = 4'b0100;
        step(); chk("c0_gnt", gnt2, 4'b0100);
        step(); chk("c0_done", done2, 4'b0100); chk("c0_tog", tog2, 0); chk("c0_q", q2, 8'h40);
        req2 = '0;
        step(); chk("c0_idle", busy2, 0); chk("c0_done_off", done2, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/tff_toggle_scheduler.md
# tff_toggle_scheduler

Round-robin scheduler that shares a bank of T flip-flops among several requesters. Each requester asks for a burst of toggles on one selected bit. The block grants one requester at a time and applies the burst one toggle per step, with an optional idle gap between toggles. It then reports completion. It sits between the tile's control inputs and the toggle bank, and it owns the bank's state.

## Interface
Parameters:
- NREQ, 4, number of requesters (2..8)
- NBITS, 8, number of T flip-flops in the bank (power of 2, 2..16)
- GAP, 0, idle cycles between consecutive toggles of one burst (0..7)

Widths: IW = $clog2(NBITS) is the index width; CW = 4 is the count width.

Ports:
- clk  in  1  single clock; all state updates on its rising edge
- rst  in  1  synchronous, active-high reset
- ena  in  1  global enable; when low, every register holds its value
- req  in  NREQ  per-requester level request; must be held until that requester's done
- tgt  in  NREQ*IW  packed target bit index; requester i uses tgt[IW*i +: IW]
- cnt  in  NREQ*CW  packed toggle count; requester i uses cnt[CW*i +: CW]
- gnt  out  NREQ  registered one-hot grant; all zero when no requester is granted
- done  out  NREQ  registered one-hot completion pulse
- busy  out  1  high in every state except IDLE
- q  out  NBITS  registered state of the toggle bank
- tog  out  NBITS  registered one-hot strobe marking the bit of q that flipped on the last edge

## Operation
Reset:
- rst=1 at an edge forces state=IDLE, q=0, gnt=0, done=0, tog=0, busy=0, round-robin pointer=0, and clears the latched target, remaining count and gap counter.
- rst has priority over ena.

ena=0:
- State, q, gnt, done, tog, pointer and all counters hold.
- A done pulse that is active stays high until ena returns.

States are IDLE, RUN, WAIT and DONE.

IDLE:
- If any req bit is set, pick the first set bit scanning upward from the pointer, wrapping modulo NREQ.
- Register gnt, and latch that requester's tgt and cnt as remaining.
- Go to RUN if cnt≠0, otherwise go to DONE.

RUN:
- Each edge: q[tgt] ^= 1, tog = one-hot(tgt), remaining -= 1.
- If the new remaining is 0, go to DONE.
- Otherwise go to WAIT if GAP>0 (gap counter loaded with GAP), or stay in RUN if GAP=0.

WAIT:
- tog=0. The gap counter decrements each edge; on reaching 0, go to RUN.

DONE:
- done = gnt and gnt = 0, both registered on entry.
- Pointer becomes (granted index + 1) mod NREQ.
- The next edge returns to IDLE with done=0.

Rules:
- tog is 0 on every edge that does not flip a bit.
- Only the latched tgt bit changes. All other q bits hold.
- Final q[tgt] = initial q[tgt] XOR cnt[0].
- Changes to req, tgt or cnt after the grant edge are ignored. A burst always completes once granted.
- A requester that drops req mid-burst still receives done.
- A req still high when the FSM returns to IDLE is a new request.
- Out-of-range tgt (NBITS not a power of 2) is not supported.

## Timing
- Request sampled at edge E0 (IDLE): gnt is valid after E0.
- With GAP=0, toggles occur at edges E1..En, where n = cnt.
- Each toggle after the first is delayed by GAP extra cycles: the k-th toggle lands at edge E(1 + (k−1)(GAP+1)).
- done is high for the one cycle after the edge following the last toggle.
- IDLE is re-entered one edge later, and the next grant comes one edge after that.
- cnt=0: gnt after E0, done after E1, IDLE after E2, no toggle.
- The requester must deassert req by the edge that returns the FSM to IDLE.
- Back-to-back grants to different requesters are separated by exactly 2 edges (DONE, then IDLE).
- rst mid-burst: effective at that edge. No done is issued and partial toggles are discarded (q=0).

## Test plan
- Reset: drive rst=1 for 2 cycles with random req. Required: q=0, gnt=0, done=0, tog=0, busy=0, pointer=0.
- Single burst, NREQ=4, GAP=0: req[2]=1, tgt=5, cnt=3. Required: gnt=4'b0100 after E0; tog=8'h20 at E1, E2 and E3; final q=8'h20; done=4'b0100 for one cycle after E4.
- Round-robin: req=4'b1111 held, each requester with cnt=1. Required: grant order 0,1,2,3,0; each requester re-asserts req after its done.
- Gap and count edges, GAP=2: cnt=2 toggles at E1 and E4. cnt=15 leaves q[tgt]=1. cnt=0 gives done after E1 with q unchanged.
- ena=0 for 3 cycles mid-burst and during done. Required: state, q and tog hold, done stays high, and the burst then resumes with the correct total toggle count.
- rst=1 for one edge mid-burst (cnt=10, 4 toggles done). Required: q=0, state IDLE, no done; a held req is re-granted starting from requester 0.
